// File: rtl/conv_sched_pkg.sv
// Shared constants, state encoding and window/weight vector types for the conv core scheduler.
package conv_sched_pkg;
    localparam int K             = 7;
    localparam int KK            = K * K;
    localparam logic [5:0] CFG_BIAS_ADDR = 6'd49;

    typedef enum logic [2:0] {IDLE, CHECK, FETCH, FIRE, WAIT, OUT, DONE} state_t;

    typedef logic [KK-1:0][7:0]  win_t;
    typedef logic [KK-1:0][15:0] wei_t;
endpackage

// File: rtl/conv_core_sched_if.sv
// Bundle of config, SRAM, conv-core and output-stream signals; master = scheduler side.
interface conv_sched_if #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
);
    import conv_sched_pkg::*;

    logic              cfg_we;
    logic [5:0]        cfg_addr;
    logic [15:0]       cfg_wdata;
    logic              start;
    logic [DIM_W-1:0]  img_w;
    logic [DIM_W-1:0]  img_h;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_rd_data;
    logic              core_enable;
    logic [KK*8-1:0]   core_ima;
    logic [KK*16-1:0]  core_wei;
    logic [15:0]       core_bias;
    logic              core_valid;
    logic [31:0]       core_out;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [DIM_W-1:0]  out_row;
    logic [DIM_W-1:0]  out_col;

    modport master (
        input  cfg_we, cfg_addr, cfg_wdata, start, img_w, img_h,
               mem_rd_data, core_valid, core_out, out_ready,
        output busy, done, err, mem_rd_en, mem_rd_addr,
               core_enable, core_ima, core_wei, core_bias,
               out_valid, out_data, out_row, out_col
    );

    modport slave (
        output cfg_we, cfg_addr, cfg_wdata, start, img_w, img_h,
               mem_rd_data, core_valid, core_out, out_ready,
        input  busy, done, err, mem_rd_en, mem_rd_addr,
               core_enable, core_ima, core_wei, core_bias,
               out_valid, out_data, out_row, out_col
    );
endinterface

// File: rtl/conv_core_sched_loader.sv
// conv_win_loader: walks the 7x7 window (ky outer, kx inner), one SRAM read per cycle,
// and drops each returned pixel into its window slot one cycle later.
module conv_win_loader
    import conv_sched_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_i,
    input  logic [DIM_W-1:0]  row_i,
    input  logic [DIM_W-1:0]  col_i,
    input  logic [DIM_W-1:0]  img_w_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [7:0]        rd_data_i,
    output logic              last_o,
    output win_t              win_o
);
    logic [5:0]        cnt_q;
    logic [2:0]        ky_q, kx_q;
    logic              rd_vld_q;
    logic [5:0]        slot_q;
    win_t              win_q;
    logic [ADDR_W-1:0] y, x;

    // cnt runs 0..49: 49 read cycles plus one to catch the final returned pixel
    assign rd_en_o   = fetch_i && (cnt_q < 6'(KK));
    assign last_o    = fetch_i && (cnt_q == 6'(KK));
    assign y         = ADDR_W'(row_i) + ADDR_W'(ky_q);
    assign x         = ADDR_W'(col_i) + ADDR_W'(kx_q);
    assign rd_addr_o = rd_en_o ? (y * ADDR_W'(img_w_i) + x) : '0;
    assign win_o     = win_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            ky_q     <= '0;
            kx_q     <= '0;
            rd_vld_q <= 1'b0;
            slot_q   <= '0;
            win_q    <= '0;
        end else begin
            rd_vld_q <= rd_en_o;
            slot_q   <= cnt_q;
            if (rd_vld_q)
                win_q[slot_q] <= rd_data_i;
            if (!fetch_i) begin
                cnt_q <= '0;
                ky_q  <= '0;
                kx_q  <= '0;
            end else if (rd_en_o) begin
                cnt_q <= cnt_q + 6'd1;
                if (kx_q == 3'(K-1)) begin
                    kx_q <= '0;
                    ky_q <= ky_q + 3'd1;
                end else begin
                    kx_q <= kx_q + 3'd1;
                end
            end
        end
    end
endmodule

// File: rtl/conv_core_sched.sv
// Job scheduler for the 7x7 conv core: FSM, weight/bias config regs, result handshake.
// Build option CONV_SCHED_RELU_EN clamps negative core results to zero.
module conv_core_sched
    import conv_sched_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    conv_sched_if.master bus
);
    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_CHECK = CHECK;
    localparam logic [2:0] S_FETCH = FETCH;
    localparam logic [2:0] S_FIRE  = FIRE;
    localparam logic [2:0] S_WAIT  = WAIT;
    localparam logic [2:0] S_OUT   = OUT;
    localparam logic [2:0] S_DONE  = DONE;

    logic [2:0]       state_q, state_d;
    logic [DIM_W-1:0] w_q, h_q;
    logic [DIM_W-1:0] row_q, row_d, col_q, col_d;
    wei_t             wei_q;
    logic [15:0]      bias_q;
    logic [31:0]      res_q, res_d;
    logic             err_q;
    logic             start_ok, cfg_ok, dims_bad, last_col, last_row, fetch_last;
    win_t             win;

    assign start_ok = (state_q == S_IDLE) && bus.start;
    // weights are frozen for the whole job; writes only land between jobs
    assign cfg_ok   = bus.cfg_we && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign dims_bad = (w_q < DIM_W'(K)) || (h_q < DIM_W'(K));
    assign last_col = (col_q == w_q - DIM_W'(K));
    assign last_row = (row_q == h_q - DIM_W'(K));

    conv_win_loader #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_i   (state_q == S_FETCH),
        .row_i     (row_q),
        .col_i     (col_q),
        .img_w_i   (w_q),
        .rd_en_o   (bus.mem_rd_en),
        .rd_addr_o (bus.mem_rd_addr),
        .rd_data_i (bus.mem_rd_data),
        .last_o    (fetch_last),
        .win_o     (win)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_CHECK;
            S_CHECK: begin
                row_d   = '0;
                col_d   = '0;
                state_d = dims_bad ? S_DONE : S_FETCH;
            end
            S_FETCH: if (fetch_last) state_d = S_FIRE;
            S_FIRE:  state_d = S_WAIT;
            S_WAIT:  if (bus.core_valid) state_d = S_OUT;
            S_OUT: begin
                if (bus.out_ready) begin
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            state_d = S_DONE;
                        end else begin
                            row_d   = row_q + DIM_W'(1);
                            state_d = S_FETCH;
                        end
                    end else begin
                        col_d   = col_q + DIM_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
`ifdef CONV_SCHED_RELU_EN
        res_d = bus.core_out[31] ? '0 : bus.core_out;
`else
        res_d = bus.core_out;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            h_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            wei_q   <= '0;
            bias_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            if (start_ok) begin
                w_q   <= bus.img_w;
                h_q   <= bus.img_h;
                err_q <= 1'b0;
            end
            if ((state_q == S_CHECK) && dims_bad)
                err_q <= 1'b1;
            if ((state_q == S_WAIT) && bus.core_valid)
                res_q <= res_d;
            if (cfg_ok) begin
                if (bus.cfg_addr < 6'(KK))
                    wei_q[bus.cfg_addr] <= bus.cfg_wdata;
                else if (bus.cfg_addr == CFG_BIAS_ADDR)
                    bias_q <= bus.cfg_wdata;
            end
        end
    end

    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.err         = err_q;
    assign bus.core_enable = (state_q == S_FIRE);
    assign bus.core_ima    = win;
    assign bus.core_wei    = wei_q;
    assign bus.core_bias   = bias_q;
    assign bus.out_valid   = (state_q == S_OUT);
    assign bus.out_data    = res_q;
    assign bus.out_row     = row_q;
    assign bus.out_col     = col_q;
endmodule
